// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and size decode helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      SZ_WORD   = 3'b000,
      SZ_HALF   = 3'b001,
      SZ_BYTE   = 3'b010,
      SZ_WORD_S = 3'b100,
      SZ_HALF_S = 3'b101,
      SZ_BYTE_S = 3'b110
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam int BUF_BYTES = 4;

   function automatic logic [2:0] beat_count(input logic [2:0] size);
      case (size)
         SZ_WORD, SZ_WORD_S: beat_count = 3'd4;
         SZ_HALF, SZ_HALF_S: beat_count = 3'd2;
         default:            beat_count = 3'd1;
      endcase
   endfunction

   // Encodings 011 and 111 have no defined width.
   function automatic logic size_invalid(input logic [2:0] size);
      size_invalid = (size[1:0] == 2'b11);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load byte assembly (inserts the current beat into the buffer) and zero/sign extension of the result.
module load_extend
   import lsu_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [31:0]       buf_data,
   input  logic [1:0]        beat,
   input  logic [7:0]        byte_in,
   input  logic [2:0]        size,
   output logic [31:0]       buf_next,
   output logic [DWIDTH-1:0] data
);

   always_comb begin
      buf_next = buf_data;
      buf_next[{beat, 3'b000} +: 8] = byte_in;
   end

   always_comb begin
      data = '0;
      case (size[1:0])
         2'b01: begin
            data[15:0] = buf_data[15:0];
            if (size[2]) data[DWIDTH-1:16] = {(DWIDTH-16){buf_data[15]}};
         end
         2'b10: begin
            data[7:0] = buf_data[7:0];
            if (size[2]) data[DWIDTH-1:8] = {(DWIDTH-8){buf_data[7]}};
         end
         default: data[31:0] = buf_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one memory byte per cycle, then a one-cycle response.
// Build option LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of splitting them.
//
// state | meaning
// IDLE  | ready for a request
// XFER  | issuing one byte beat per cycle
// RESP  | rsp_valid pulse, then back to IDLE
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   state_e              state_q, state_d;
   logic                we_q;
   logic [2:0]          size_q;
   logic [AWIDTH-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [1:0]          beat_q;
   logic [31:0]         buf_q;
   logic [31:0]         buf_next;
   logic                err_q;
   logic                accept;
   logic                reject;
   logic                misaligned;
   logic [1:0]          last_beat;
   logic [DWIDTH-1:0]   ext_data;

`ifdef LSU_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      case (req_size[1:0])
         2'b00:   misaligned = (req_addr[1:0] != 2'b00);
         2'b01:   misaligned = req_addr[0];
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   assign reject    = size_invalid(req_size) || misaligned;
   assign last_beat = 2'(beat_count(size_q) - 3'd1);

   load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
      .buf_data (buf_q),
      .beat     (beat_q),
      .byte_in  (mem_rdata),
      .size     (size_q),
      .buf_next (buf_next),
      .data     (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      case (state_q)
         IDLE: begin
            req_ready = !rst;
            accept    = req_valid && !rst;
            if (accept) state_d = reject ? RESP : XFER;
         end
         XFER: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q + AWIDTH'(beat_q);
            mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
            if (beat_q == last_beat) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q && !we_q) rsp_rdata = ext_data;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         beat_q  <= 2'd0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[31:0];
            beat_q  <= 2'd0;
            buf_q   <= '0;
            err_q   <= reject;
         end else if (state_q == XFER) begin
            beat_q <= beat_q + 2'd1;
            if (!we_q) buf_q <= buf_next;
         end
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning core data width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have these request-side ports:
- req_valid  input  1  core presents an access.
- req_ready  output  1  unit can accept an access.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  3  size_type: 000 word, 001 half, 010 byte, 100 word signed, 101 half signed, 110 byte signed.
- req_addr  input  AWIDTH  byte address.
- req_wdata  input  DWIDTH  store data, LSB-aligned.
REQ-005 SHALL have these response-side ports:
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DWIDTH  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected; valid only with rsp_valid.
REQ-006 SHALL have these byte-memory ports:
- mem_en  output  1  beat active.
- mem_we  output  1  byte write strobe.
- mem_addr  output  AWIDTH  byte address of the beat.
- mem_wdata  output  8  byte to write.
- mem_rdata  input  8  asynchronous read data for mem_addr, same cycle.

Function
REQ-007 SHALL implement an FSM with states IDLE, XFER and RESP.
REQ-008 SHALL assert req_ready only in IDLE with rst low, and SHALL accept a request when req_valid and req_ready are both high at a clock edge.
REQ-009 SHALL latch we, size, addr and wdata on acceptance and ignore request inputs until the unit returns to IDLE.
REQ-010 SHALL set the beat count N to 4 for word, 2 for half and 1 for byte accesses.
REQ-011 SHALL, in XFER, issue exactly one beat per cycle for beats k = 0..N-1:
- mem_en = 1, mem_addr = addr + k (mod 2^AWIDTH), mem_we = we.
- mem_wdata = wdata[8k+7:8k].
REQ-012 SHALL, on a load, capture mem_rdata into byte k of the assembly buffer at the end of beat k.
REQ-013 SHALL write only N bytes on a store and SHALL NOT touch addr+N..addr+3.
REQ-014 SHALL enter RESP after beat N-1, pulse rsp_valid for exactly one cycle, then return to IDLE.
REQ-015 SHALL produce rsp_rdata as follows:
- Unsigned half/byte: zero-extended.
- Signed half/byte: sign-extended from bit 15 or bit 7.
- Word: as assembled.
REQ-016 SHALL have this latency: acceptance at edge E, beats in cycles E+1..E+N, rsp_valid in cycle E+N+1; back-to-back throughput is one access per N+2 cycles.
REQ-017 SHALL treat req_size 011 or 111 as an error: no beats issued, direct IDLE->RESP transition, rsp_err = 1, rsp_rdata = 0.
REQ-018 SHALL hold mem_en and mem_we at 0 in IDLE and RESP.

Reset
REQ-019 SHALL, with rst high at an edge, force state to IDLE and clear the beat counter and assembly buffer.
REQ-020 SHALL drive rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr and mem_wdata to 0 after that edge, and hold req_ready at 0 while rst is high.
REQ-021 SHALL, on reset mid-XFER, abandon the access: remaining beats are not issued, no response is produced, and bytes already written remain written.

Configuration
REQ-022 SHALL support macro LSU_ALIGN_CHECK_EN:
- Defined: a half access with addr[0] != 0 or a word access with addr[1:0] != 0 is rejected as in REQ-017 (no beats, rsp_err = 1).
- Undefined: any address is legal and beats proceed bytewise, including wrap past 2^AWIDTH-1.

Structure
REQ-023 SHALL place size_type encodings and the FSM state encoding in shared package lsu_pkg.
REQ-024 SHALL implement byte assembly and zero/sign extension in one combinational sub-module, load_extend.

Verification
REQ-025 SHALL cover these directed scenarios:
- Store word: addr 0x10, wdata 0xDEADBEEF -> beats write EF, BE, AD, DE to 0x10..0x13; rsp_valid at cycle E+5, rsp_err = 0.
- Load half signed: bytes 0x20 = 0x34, 0x21 = 0x92 -> rsp_rdata 0xFFFF9234; same access as half unsigned -> 0x00009234.
- Store byte: addr 0x40, wdata 0x12345678 with 0x41 preloaded 0xAA -> 0x40 = 0x78, 0x41 stays 0xAA; a subsequent byte-signed load from 0x40 -> 0x00000078.
- req_size 111 -> no mem_en pulse, rsp_valid with rsp_err = 1 one cycle after acceptance.
- Word load at addr 0x21: with LSU_ALIGN_CHECK_EN -> rsp_err = 1, no beats; without -> four beats at 0x21..0x24, correct data.
- rst asserted during beat 2 of a word store -> beats 3 and 4 absent, no rsp_valid, req_ready = 1 in the first cycle after rst falls.
